// File: rtl/jk_reg_sequencer_pkg.sv
// Shared definitions for the JK register sequencer.
//  - Opcode encodings OP_NOP .. OP_ILL
//  - FSM state encoding state_t (ST_IDLE, ST_EXEC, ST_SHIFT, ST_DONE)
//  - is_shift_op(): true for the multi-cycle shift opcodes
package jk_seq_pkg;

   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_LOAD   = 3'b001;
   localparam logic [2:0] OP_SET    = 3'b010;
   localparam logic [2:0] OP_CLEAR  = 3'b011;
   localparam logic [2:0] OP_TOGGLE = 3'b100;
   localparam logic [2:0] OP_SHL    = 3'b101;
   localparam logic [2:0] OP_SHR    = 3'b110;
   localparam logic [2:0] OP_ILL    = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic is_shift_op(input logic [2:0] op);
      return (op == OP_SHL) || (op == OP_SHR);
   endfunction

endpackage

// File: rtl/jk_reg_sequencer_if.sv
// Command handshake bundle for jk_reg_sequencer.
//  cmd_valid/cmd_ready : valid/ready handshake (ready driven by the sequencer)
//  cmd_op              : 3-bit opcode
//  cmd_data            : LOAD data, WIDTH bits
//  cmd_mask            : per-bit enable for LOAD/SET/CLEAR/TOGGLE
//  cmd_shamt           : shift step count, $clog2(WIDTH) bits
// Modports: master = requester, slave = sequencer.
interface jk_reg_sequencer_if #(
   parameter int WIDTH = 8
);
   localparam int SHW = $clog2(WIDTH);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [WIDTH-1:0] cmd_mask;
   logic [SHW-1:0]   cmd_shamt;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_mask, cmd_shamt,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_mask, cmd_shamt,
      output cmd_ready
   );

endinterface

// File: rtl/jk_reg_sequencer_bit_cell.sv
// jk_bit_cell: one JK flip-flop with synchronous active-high reset.
//  clk, rst : clock, synchronous reset (q -> 0)
//  j, k     : 00 hold, 01 clear, 10 set, 11 toggle
//  q, q_bar : state and its complement
module jk_bit_cell (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q,
   output logic q_bar
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

   assign q_bar = ~q;

endmodule

// File: rtl/jk_reg_sequencer.sv
// jk_reg_sequencer: command sequencer in front of a WIDTH-bit JK register bank.
// Accepts one command per handshake and drives per-bit J/K for LOAD, SET,
// CLEAR, TOGGLE (single step) or SHL/SHR (one position per cycle).
//  clk, rst       : clock, synchronous active-high reset
//  bus            : command handshake (jk_reg_sequencer_if.slave)
//  ser_in         : serial fill bit used on every shift step
//  q, q_bar       : register state and complement
//  j_out, k_out   : J/K drive into the bank
//  busy           : high in EXEC, SHIFT and DONE
//  done, err      : one-cycle completion pulse; err flags an illegal opcode
// Optional: define JK_SEQ_PERF_EN to add cmd_count[15:0], a wrapping count of
// completed commands (including illegal-opcode completions).
module jk_reg_sequencer
   import jk_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   jk_reg_sequencer_if.slave bus,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic             busy,
   output logic             done,
`ifdef JK_SEQ_PERF_EN
   output logic [15:0]      cmd_count,
`endif
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);

   state_t           state;
   logic             ready_r;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] mask_r;
   logic [SHW-1:0]   shamt_r;
   logic [SHW-1:0]   cnt;
   logic [WIDTH-1:0] shift_nxt;
   logic             accept;
   logic             finish;

   assign accept        = bus.cmd_valid & ready_r;
   assign bus.cmd_ready = ready_r;

   // The first SHIFT cycle (cnt == 0) only primes the step counter; the
   // register moves on the following shamt edges, so the last step lands on
   // the same edge that enters DONE.
   assign finish = (state == ST_EXEC) || ((state == ST_SHIFT) && (cnt == shamt_r));

   // Command fields are captured on accept only; they need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_r    <= bus.cmd_op;
         data_r  <= bus.cmd_data;
         mask_r  <= bus.cmd_mask;
         shamt_r <= bus.cmd_shamt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ready_r <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  ready_r <= 1'b0;
                  busy    <= 1'b1;
                  cnt     <= '0;
                  // A zero-length shift degenerates to a single-step NOP.
                  if (is_shift_op(bus.cmd_op) && (bus.cmd_shamt != '0))
                     state <= ST_SHIFT;
                  else
                     state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               state <= ST_DONE;
               done  <= 1'b1;
               err   <= (op_r == OP_ILL);
            end
            ST_SHIFT: begin
               cnt <= cnt + SHW'(1);
               if (finish) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               ready_r <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef JK_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (rst)
         cmd_count <= 16'h0000;
      else if (finish)
         cmd_count <= cmd_count + 16'h0001;
   end
`endif

   always_comb begin
      j_out     = '0;
      k_out     = '0;
      shift_nxt = (op_r == OP_SHL) ? {q[WIDTH-2:0], ser_in} : {ser_in, q[WIDTH-1:1]};
      case (state)
         ST_EXEC: begin
            case (op_r)
               OP_LOAD: begin
                  j_out = data_r & mask_r;
                  k_out = ~data_r & mask_r;
               end
               OP_SET:    j_out = mask_r;
               OP_CLEAR:  k_out = mask_r;
               OP_TOGGLE: begin
                  j_out = mask_r;
                  k_out = mask_r;
               end
               default: ;
            endcase
         end
         ST_SHIFT: begin
            if (cnt != '0) begin
               j_out = shift_nxt;
               k_out = ~shift_nxt;
            end
         end
         default: ;
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_bit_cell u_cell (
         .clk   (clk),
         .rst   (rst),
         .j     (j_out[i]),
         .k     (k_out[i]),
         .q     (q[i]),
         .q_bar (q_bar[i])
      );
   end

endmodule

// File: tb/tb_jk_reg_sequencer.sv
// Self-checking bench for jk_reg_sequencer (WIDTH=8) with a behavioural
// reference model of the register contents and handshake timing.
module tb_jk_reg_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ser_in = 1'b0;
   logic [7:0] q, q_bar, j_out, k_out;
   logic       busy, done, err;
`ifdef JK_SEQ_PERF_EN
   logic [15:0] cmd_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] model_q = 8'h00;
   int exp_count = 0;

   jk_reg_sequencer_if #(.WIDTH(8)) bus ();

   jk_reg_sequencer #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .ser_in    (ser_in),
      .q         (q),
      .q_bar     (q_bar),
      .j_out     (j_out),
      .k_out     (k_out),
      .busy      (busy),
      .done      (done),
`ifdef JK_SEQ_PERF_EN
      .cmd_count (cmd_count),
`endif
      .err       (err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
      $fatal(1, "watchdog");
   end

   // Register contents after applying a command; for shifts, 'steps' positions.
   function automatic logic [7:0] mdl(input logic [7:0] cur, input logic [2:0] op,
                                      input logic [7:0] d, input logic [7:0] m,
                                      input logic s, input int steps);
      int v;
      v = int'(cur);
      case (op)
         3'd1: v = int'((cur & ~m) | (d & m));
         3'd2: v = int'(cur | m);
         3'd3: v = int'(cur & ~m);
         3'd4: v = int'(cur ^ m);
         3'd5: for (int i = 0; i < steps; i++) v = (v * 2 + int'(s)) % 256;
         3'd6: for (int i = 0; i < steps; i++) v = v / 2 + int'(s) * 128;
         default: ;
      endcase
      return v[7:0];
   endfunction

   task automatic check_count();
`ifdef JK_SEQ_PERF_EN
      n_checks++;
      if (cmd_count !== 16'(exp_count)) begin
         n_fail++;
         $display("FAIL cmd_count: actual %h required %h", cmd_count, 16'(exp_count));
      end
`endif
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, input logic [7:0] m,
                          input logic [2:0] sh, input logic s);
      logic [7:0] start_q, exp_q, ej, ek;
      int n;
      bit is_sh, got;
      is_sh = (op == 3'd5 || op == 3'd6) && (sh != 3'd0);
      n = is_sh ? int'(sh) + 1 : 1;
      got = 0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.cmd_ready === 1'b1) begin
            got = 1;
            break;
         end
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL ready_wait: actual cmd_ready=%b required 1 within 50 cycles", bus.cmd_ready);
         return;
      end
      start_q = model_q;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      bus.cmd_mask  = m;
      bus.cmd_shamt = sh;
      ser_in        = s;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || bus.cmd_ready !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL accept_state op=%0d: actual busy=%b ready=%b done=%b required 1 0 0",
                  op, busy, bus.cmd_ready, done);
      end
      if (!is_sh) begin
         ej = 8'h00;
         ek = 8'h00;
         case (op)
            3'd1: begin ej = d & m; ek = ~d & m; end
            3'd2: ej = m;
            3'd3: ek = m;
            3'd4: begin ej = m; ek = m; end
            default: ;
         endcase
         n_checks++;
         if (j_out !== ej || k_out !== ek) begin
            n_fail++;
            $display("FAIL jk_drive op=%0d: actual j=%h k=%h required j=%h k=%h",
                     op, j_out, k_out, ej, ek);
         end
      end
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         exp_q = mdl(start_q, op, d, m, s, k - 1);
         n_checks++;
         if (q !== exp_q || q_bar !== ~exp_q) begin
            n_fail++;
            $display("FAIL q op=%0d cycle %0d: actual q=%h q_bar=%h required q=%h q_bar=%h",
                     op, k, q, q_bar, exp_q, ~exp_q);
         end
         n_checks++;
         if (k < n) begin
            if (done !== 1'b0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL early_done op=%0d cycle %0d: actual done=%b busy=%b required 0 1",
                        op, k, done, busy);
            end
         end else begin
            if (done !== 1'b1 || busy !== 1'b1 || err !== (op == 3'd7)) begin
               n_fail++;
               $display("FAIL done_pulse op=%0d cycle %0d: actual done=%b busy=%b err=%b required 1 1 %b",
                        op, k, done, busy, err, (op == 3'd7));
            end
         end
      end
      model_q = mdl(start_q, op, d, m, s, int'(sh));
      exp_count++;
      @(negedge clk);
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
          j_out !== 8'h00 || k_out !== 8'h00 || q !== model_q) begin
         n_fail++;
         $display("FAIL back_idle op=%0d: actual ready=%b busy=%b done=%b err=%b j=%h k=%h q=%h required 1 0 0 0 00 00 %h",
                  op, bus.cmd_ready, busy, done, err, j_out, k_out, q, model_q);
      end
      check_count();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (q !== 8'h00 || q_bar !== 8'hFF || bus.cmd_ready !== 1'b1 || busy !== 1'b0 ||
          done !== 1'b0 || err !== 1'b0 || j_out !== 8'h00 || k_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset: actual q=%h q_bar=%h ready=%b busy=%b done=%b err=%b j=%h k=%h required 00 FF 1 0 0 0 00 00",
                  q, q_bar, bus.cmd_ready, busy, done, err, j_out, k_out);
      end
      model_q = 8'h00;
      exp_count = 0;
      check_count();
      rst = 1'b0;
   endtask

   task automatic test_single_ops();
      run_cmd(3'd1, 8'hA5, 8'hFF, 3'd0, 1'b0);
      run_cmd(3'd4, 8'h00, 8'h0F, 3'd0, 1'b0);
      run_cmd(3'd3, 8'h00, 8'hF0, 3'd0, 1'b0);
      run_cmd(3'd2, 8'h00, 8'h80, 3'd0, 1'b0);
      n_checks++;
      if (q !== 8'h8A) begin
         n_fail++;
         $display("FAIL single_ops_final: actual %h required 8a", q);
      end
      run_cmd(3'd0, 8'hFF, 8'hFF, 3'd0, 1'b1);
   endtask

   task automatic test_shift();
      run_cmd(3'd1, 8'h81, 8'hFF, 3'd0, 1'b0);
      run_cmd(3'd5, 8'h00, 8'h00, 3'd3, 1'b1);
      run_cmd(3'd6, 8'h00, 8'h00, 3'd2, 1'b0);
      n_checks++;
      if (q !== 8'h03) begin
         n_fail++;
         $display("FAIL shift_final: actual %h required 03", q);
      end
      run_cmd(3'd5, 8'h00, 8'h00, 3'd0, 1'b1);
      run_cmd(3'd6, 8'h00, 8'h00, 3'd7, 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [7:0] start_q, exp_q;
      bit got;
      run_cmd(3'd1, 8'h69, 8'hFF, 3'd0, 1'b0);
      start_q = model_q;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd5;
      bus.cmd_shamt = 3'd7;
      bus.cmd_mask  = 8'hFF;
      bus.cmd_data  = 8'h00;
      ser_in        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_op    = 3'd1;
      bus.cmd_data  = 8'h3C;
      bus.cmd_mask  = 8'hFF;
      bus.cmd_shamt = 3'd0;
      got = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp_q = mdl(start_q, 3'd5, 8'h00, 8'h00, 1'b1, k - 1);
         n_checks++;
         if (q !== exp_q || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL held_cmd cycle %0d: actual q=%h ready=%b required q=%h ready=0",
                     k, q, bus.cmd_ready, exp_q);
         end
         if (done === 1'b1) got = 1;
      end
      n_checks++;
      if (!got) begin
         n_fail++;
         $display("FAIL held_done: actual no done in 8 cycles required done after 8th");
      end
      exp_count++;
      model_q = mdl(start_q, 3'd5, 8'h00, 8'h00, 1'b1, 7);
      @(negedge clk);
      n_checks++;
      if (bus.cmd_ready !== 1'b1 || q !== model_q) begin
         n_fail++;
         $display("FAIL held_ready: actual ready=%b q=%h required 1 %h", bus.cmd_ready, q, model_q);
      end
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || q !== model_q) begin
         n_fail++;
         $display("FAIL held_accept: actual busy=%b q=%h required 1 %h", busy, q, model_q);
      end
      @(negedge clk);
      n_checks++;
      if (q !== 8'h3C || done !== 1'b1) begin
         n_fail++;
         $display("FAIL held_load: actual q=%h done=%b required 3c 1", q, done);
      end
      model_q = 8'h3C;
      exp_count++;
      @(negedge clk);
      check_count();
   endtask

   task automatic test_reset_mid_shift();
      bit seen;
      run_cmd(3'd1, 8'hC3, 8'hFF, 3'd0, 1'b0);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd5;
      bus.cmd_shamt = 3'd5;
      ser_in        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (q !== 8'h00 || q_bar !== 8'hFF || bus.cmd_ready !== 1'b1 || busy !== 1'b0 ||
          done !== 1'b0 || j_out !== 8'h00 || k_out !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_reset: actual q=%h q_bar=%h ready=%b busy=%b done=%b j=%h k=%h required 00 FF 1 0 0 00 00",
                  q, q_bar, bus.cmd_ready, busy, done, j_out, k_out);
      end
      rst = 1'b0;
      model_q = 8'h00;
      exp_count = 0;
      check_count();
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) seen = 1;
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL mid_reset_quiet: actual done/busy activity after abort required none");
      end
   endtask

   task automatic test_illegal();
      run_cmd(3'd1, 8'h5A, 8'hFF, 3'd0, 1'b0);
      run_cmd(3'd7, 8'hFF, 8'hFF, 3'd3, 1'b1);
      n_checks++;
      if (q !== 8'h5A) begin
         n_fail++;
         $display("FAIL illegal_hold: actual %h required 5a", q);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         run_cmd(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                 3'($urandom_range(0, 7)), 1'($urandom));
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
      bus.cmd_data  = 8'h00;
      bus.cmd_mask  = 8'h00;
      bus.cmd_shamt = 3'd0;
      test_reset();
      test_single_ops();
      test_shift();
      test_back_to_back();
      test_reset_mid_shift();
      test_illegal();
      test_random();
      test_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
